// File: rtl/magic_seq_checker_pkg.sv
// magic_pkg: shared types and the line-to-element table for the sequential
// 3x3 magic-square checker.
`default_nettype none

package magic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] line_idx_t;
    typedef logic [3:0] elem_idx_t;

    localparam int        NUM_LINES = 8;
    localparam line_idx_t LAST_LINE = 3'(NUM_LINES - 1);

    // Element indices (0 = num1 ... 8 = num9): rows, columns, main diag, anti diag.
    localparam elem_idx_t LINE_TRIPLE [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

`default_nettype wire

// File: rtl/magic_seq_checker_if.sv
// magic_seq_checker_if: start/element inputs and result outputs of the checker.
`default_nettype none

interface magic_seq_checker_if
    import magic_pkg::*;
#(
    parameter int W  = 4,
    parameter int SW = 8
);
    logic            start;
    logic [W-1:0]    num1, num2, num3, num4, num5, num6, num7, num8, num9;
    logic            busy;
    logic            done;
    logic            it_is_magic;
    logic [SW-1:0]   magic_constant;
    line_idx_t       fail_line;

    modport master (
        output start, num1, num2, num3, num4, num5, num6, num7, num8, num9,
        input  busy, done, it_is_magic, magic_constant, fail_line
    );

    modport slave (
        input  start, num1, num2, num3, num4, num5, num6, num7, num8, num9,
        output busy, done, it_is_magic, magic_constant, fail_line
    );

endinterface

`default_nettype wire

// File: rtl/magic_add3.sv
// magic_add3: three-input adder, operands zero-extended to the sum width.
`default_nettype none

module magic_add3 #(
    parameter int W  = 4,
    parameter int SW = 8
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  c,
    output logic [SW-1:0] sum
);

    assign sum = SW'(a) + SW'(b) + SW'(c);

endmodule

`default_nettype wire

// File: rtl/magic_seq_checker_line_sel.sv
// magic_line_sel: picks the three captured elements that make up one line.
`default_nettype none

module magic_line_sel
    import magic_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] elems [9],
    input  line_idx_t    line,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] op_c
);

    always_comb begin
        op_a = elems[LINE_TRIPLE[line][0]];
        op_b = elems[LINE_TRIPLE[line][1]];
        op_c = elems[LINE_TRIPLE[line][2]];
    end

endmodule

`default_nettype wire

// File: rtl/magic_seq_checker.sv
// magic_seq_checker: sequential 3x3 magic-square check, one line sum per clock
// through a single shared three-input adder.
`default_nettype none

module magic_seq_checker
    import magic_pkg::*;
#(
    parameter int W          = 4,
    parameter int SW         = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    magic_seq_checker_if.slave  bus
);

    state_t       state;
    line_idx_t    line;
    logic         mismatch;
    logic [W-1:0] elems [9];
    logic [W-1:0] op_a, op_b, op_c;
    logic [SW-1:0] line_sum;
    logic         line_bad;
    logic         finish;

    magic_line_sel #(.W(W)) u_line_sel (
        .elems (elems),
        .line  (line),
        .op_a  (op_a),
        .op_b  (op_b),
        .op_c  (op_c)
    );

    magic_add3 #(.W(W), .SW(SW)) u_add3 (
        .a   (op_a),
        .b   (op_b),
        .c   (op_c),
        .sum (line_sum)
    );

    // Line 0 defines the constant, so it can never mismatch.
    assign line_bad = (line != '0) && (line_sum != bus.magic_constant);
    assign finish   = (line == LAST_LINE) || (line_bad && EARLY_EXIT);

    // Element copy needs no reset: it is only read after a fresh capture.
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.start) begin
            elems[0] <= bus.num1;
            elems[1] <= bus.num2;
            elems[2] <= bus.num3;
            elems[3] <= bus.num4;
            elems[4] <= bus.num5;
            elems[5] <= bus.num6;
            elems[6] <= bus.num7;
            elems[7] <= bus.num8;
            elems[8] <= bus.num9;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            line               <= '0;
            mismatch           <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.it_is_magic    <= 1'b0;
            bus.magic_constant <= '0;
            bus.fail_line      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state              <= CALC;
                        line               <= '0;
                        mismatch           <= 1'b0;
                        bus.busy           <= 1'b1;
                        bus.it_is_magic    <= 1'b0;
                        bus.magic_constant <= '0;
                        bus.fail_line      <= '0;
                    end
                end
                CALC: begin
                    if (line == '0) begin
                        bus.magic_constant <= line_sum;
                    end else if (line_bad) begin
                        mismatch <= 1'b1;
                        if (!mismatch) begin
                            bus.fail_line <= line;
                        end
                    end
                    if (finish) begin
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.it_is_magic <= !(mismatch || line_bad);
                    end else begin
                        line <= line + 3'd1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_magic_seq_checker.sv
// tb_magic_seq_checker: drives an early-exit and a full-evaluation checker with
// the same squares and compares both against a line-sum reference model.
`default_nettype none

module tb_magic_seq_checker;

    localparam int W  = 4;
    localparam int SW = 8;
    localparam int WINDOW = 12;

    localparam int LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    magic_seq_checker_if #(.W(W), .SW(SW)) if_e ();
    magic_seq_checker_if #(.W(W), .SW(SW)) if_f ();

    magic_seq_checker #(.W(W), .SW(SW), .EARLY_EXIT(1'b1)) dut_e (
        .clock (clock),
        .reset (reset),
        .bus   (if_e.slave)
    );

    magic_seq_checker #(.W(W), .SW(SW), .EARLY_EXIT(1'b0)) dut_f (
        .clock (clock),
        .reset (reset),
        .bus   (if_f.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_nums(input int e[9]);
        if_e.num1 = W'(e[0]); if_f.num1 = W'(e[0]);
        if_e.num2 = W'(e[1]); if_f.num2 = W'(e[1]);
        if_e.num3 = W'(e[2]); if_f.num3 = W'(e[2]);
        if_e.num4 = W'(e[3]); if_f.num4 = W'(e[3]);
        if_e.num5 = W'(e[4]); if_f.num5 = W'(e[4]);
        if_e.num6 = W'(e[5]); if_f.num6 = W'(e[5]);
        if_e.num7 = W'(e[6]); if_f.num7 = W'(e[6]);
        if_e.num8 = W'(e[7]); if_f.num8 = W'(e[7]);
        if_e.num9 = W'(e[8]); if_f.num9 = W'(e[8]);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, ".e.busy"},  32'(if_e.busy), 0);
        chk({tag, ".e.done"},  32'(if_e.done), 0);
        chk({tag, ".e.magic"}, 32'(if_e.it_is_magic), 0);
        chk({tag, ".e.const"}, 32'(if_e.magic_constant), 0);
        chk({tag, ".e.fail"},  32'(if_e.fail_line), 0);
        chk({tag, ".f.busy"},  32'(if_f.busy), 0);
        chk({tag, ".f.done"},  32'(if_f.done), 0);
        chk({tag, ".f.magic"}, 32'(if_f.it_is_magic), 0);
        chk({tag, ".f.const"}, 32'(if_f.magic_constant), 0);
        chk({tag, ".f.fail"},  32'(if_f.fail_line), 0);
    endtask

    // Pulses start, then watches both checkers for WINDOW cycles.
    // At cycle disturb_at the inputs go to zero and start is pulsed again.
    task automatic run(input string tag, input int e[9], input int disturb_at);
        int mc, first_bad, s;
        int exp_lat [2];
        int busy_n [2], done_n [2], done_at [2];
        int zero9 [9];

        mc = e[LINES[0][0]] + e[LINES[0][1]] + e[LINES[0][2]];
        first_bad = -1;
        for (int l = 1; l < 8; l++) begin
            s = e[LINES[l][0]] + e[LINES[l][1]] + e[LINES[l][2]];
            if (s != mc && first_bad < 0) first_bad = l;
        end
        exp_lat[0] = (first_bad >= 0) ? first_bad + 1 : 8;
        exp_lat[1] = 8;
        for (int i = 0; i < 9; i++) zero9[i] = 0;
        for (int d = 0; d < 2; d++) begin
            busy_n[d] = 0; done_n[d] = 0; done_at[d] = -1;
        end

        set_nums(e);
        @(negedge clock);
        if_e.start = 1'b1; if_f.start = 1'b1;
        @(posedge clock); #1;
        if_e.start = 1'b0; if_f.start = 1'b0;

        for (int c = 0; c < WINDOW; c++) begin
            if (if_e.busy) busy_n[0]++;
            if (if_f.busy) busy_n[1]++;
            if (if_e.done) begin done_n[0]++; done_at[0] = c; end
            if (if_f.done) begin done_n[1]++; done_at[1] = c; end
            if (c == disturb_at) begin
                set_nums(zero9);
                if_e.start = 1'b1; if_f.start = 1'b1;
            end else begin
                if_e.start = 1'b0; if_f.start = 1'b0;
            end
            @(posedge clock); #1;
        end
        if_e.start = 1'b0; if_f.start = 1'b0;

        chk({tag, ".e.done_cnt"},  32'(done_n[0]), 1);
        chk({tag, ".e.latency"},   32'(done_at[0]), 32'(exp_lat[0]));
        chk({tag, ".e.busy_cyc"},  32'(busy_n[0]), 32'(exp_lat[0]));
        chk({tag, ".e.magic"},     32'(if_e.it_is_magic), 32'(first_bad < 0));
        chk({tag, ".e.const"},     32'(if_e.magic_constant), 32'(mc));
        chk({tag, ".e.fail"},      32'(if_e.fail_line), 32'((first_bad < 0) ? 0 : first_bad));
        chk({tag, ".f.done_cnt"},  32'(done_n[1]), 1);
        chk({tag, ".f.latency"},   32'(done_at[1]), 32'(exp_lat[1]));
        chk({tag, ".f.busy_cyc"},  32'(busy_n[1]), 32'(exp_lat[1]));
        chk({tag, ".f.magic"},     32'(if_f.it_is_magic), 32'(first_bad < 0));
        chk({tag, ".f.const"},     32'(if_f.magic_constant), 32'(mc));
        chk({tag, ".f.fail"},      32'(if_f.fail_line), 32'((first_bad < 0) ? 0 : first_bad));
    endtask

    initial begin
        int lo_shu [9]  = '{2, 7, 6, 9, 5, 1, 4, 3, 8};
        int all15 [9]   = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        int seq19 [9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int latin [9]   = '{1, 2, 3, 2, 3, 1, 3, 1, 2};
        int sq [9];
        int dn;
        int r, c, rr, cc, t, k, idx;
        bit tr, fl;

        if_e.start = 1'b0; if_f.start = 1'b0;
        set_nums(lo_shu);
        repeat (3) @(posedge clock);
        #1;
        check_idle_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_idle_zero("idle_no_start");

        run("loshu", lo_shu, -1);
        run("all15", all15, -1);
        run("seq19", seq19, -1);
        run("latin", latin, -1);
        run("disturb", lo_shu, 2);

        // Reset three cycles into CALC, then a clean run.
        set_nums(lo_shu);
        @(negedge clock);
        if_e.start = 1'b1; if_f.start = 1'b1;
        @(posedge clock); #1;
        if_e.start = 1'b0; if_f.start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_idle_zero("mid_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < WINDOW; i++) begin
            @(posedge clock); #1;
            if (if_e.done || if_f.done) dn++;
        end
        chk("mid_reset.no_done", 32'(dn), 0);
        run("after_reset", lo_shu, -1);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < 9; i++) sq[i] = int'($urandom_range(0, 15));
                end
                default: begin
                    k  = int'($urandom_range(0, 6));
                    tr = 1'($urandom_range(0, 1));
                    fl = 1'($urandom_range(0, 1));
                    for (int i = 0; i < 9; i++) begin
                        r = i / 3; c = i % 3;
                        rr = r; cc = c;
                        if (tr) begin t = rr; rr = cc; cc = t; end
                        if (fl) cc = 2 - cc;
                        sq[i] = lo_shu[rr * 3 + cc] + k;
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        idx = int'($urandom_range(0, 8));
                        sq[idx] = (sq[idx] < 15) ? sq[idx] + 1 : sq[idx] - 1;
                    end
                end
            endcase
            run($sformatf("rand%0d", it), sq, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
